// File: rtl/eth_phy_10g_link_ctrl_if.sv
// Control, status and PHY-side signals of the 10G link bring-up sequencer.
// The controller is the slave; whoever drives start/stop and the PHY status is the master.
interface eth_phy_10g_link_ctrl_if;
    logic        start;
    logic        stop;
    logic        prbs_test_en;
    logic        rx_block_lock;
    logic        rx_high_ber;
    logic [6:0]  rx_error_count;
    logic        serdes_rx_reset_req;
    logic        cfg_tx_prbs31_enable;
    logic        cfg_rx_prbs31_enable;
    logic        link_up;
    logic        link_fail;
    logic [2:0]  state;
    logic [3:0]  retry_count;
    logic [15:0] prbs_err_total;

    modport master (
        output start, stop, prbs_test_en, rx_block_lock, rx_high_ber, rx_error_count,
        input  serdes_rx_reset_req, cfg_tx_prbs31_enable, cfg_rx_prbs31_enable,
               link_up, link_fail, state, retry_count, prbs_err_total
    );

    modport slave (
        input  start, stop, prbs_test_en, rx_block_lock, rx_high_ber, rx_error_count,
        output serdes_rx_reset_req, cfg_tx_prbs31_enable, cfg_rx_prbs31_enable,
               link_up, link_fail, state, retry_count, prbs_err_total
    );
endinterface

// File: rtl/eth_phy_10g_link_ctrl.sv
// Link bring-up sequencer for the eth_phy_10g PCS: SERDES rx reset, block-lock wait,
// optional PRBS31 self-test, bounded retries and automatic restart on link loss.
module eth_phy_10g_link_ctrl #(
    parameter int RESET_HOLD   = 8,
    parameter int LOCK_TIMEOUT = 1024,
    parameter int MAX_RETRIES  = 3,
    parameter int PRBS_SETTLE  = 16,
    parameter int PRBS_CYCLES  = 256,
    parameter int PRBS_MAX_ERR = 0
) (
    input  logic                  rx_clk,
    input  logic                  rx_rst,
    eth_phy_10g_link_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RESET     = 3'd1,
        ST_WAIT_LOCK = 3'd2,
        ST_PRBS      = 3'd3,
        ST_LINK_UP   = 3'd4,
        ST_FAIL      = 3'd5
    } state_t;

    localparam int TIMER_MAX_A = (RESET_HOLD > LOCK_TIMEOUT) ? RESET_HOLD : LOCK_TIMEOUT;
    localparam int TIMER_MAX   = (TIMER_MAX_A > PRBS_CYCLES) ? TIMER_MAX_A : PRBS_CYCLES;
    localparam int TIMER_W     = $clog2(TIMER_MAX + 1);

    state_t             state_q;
    logic [TIMER_W-1:0] timer_q;
    logic               prbs_mode_q;
    logic [3:0]         retry_q;
    logic [15:0]        err_total_q;
    logic               reset_req_q;
    logic               prbs_en_q;
    logic               link_up_q;
    logic               link_fail_q;

    logic               lock_ok;
    logic [16:0]        err_sum;
    logic [15:0]        err_next;
    logic               prbs_pass;

    assign lock_ok = bus.rx_block_lock && !bus.rx_high_ber;

    // Running PRBS total including this cycle's count, so the final cycle is part of the verdict.
    assign err_sum   = {1'b0, err_total_q} + {10'd0, bus.rx_error_count};
    assign err_next  = (timer_q >= TIMER_W'(PRBS_SETTLE))
                       ? (err_sum[16] ? 16'hFFFF : err_sum[15:0])
                       : err_total_q;
    assign prbs_pass = ({16'd0, err_next} <= 32'(PRBS_MAX_ERR));

    always_ff @(posedge rx_clk) begin
        if (rx_rst) begin
            state_q     <= ST_IDLE;
            timer_q     <= '0;
            prbs_mode_q <= 1'b0;
            retry_q     <= '0;
            err_total_q <= '0;
            reset_req_q <= 1'b0;
            prbs_en_q   <= 1'b0;
            link_up_q   <= 1'b0;
            link_fail_q <= 1'b0;
        end else if (bus.stop) begin
            state_q     <= ST_IDLE;
            reset_req_q <= 1'b0;
            prbs_en_q   <= 1'b0;
            link_up_q   <= 1'b0;
            link_fail_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_FAIL: begin
                    if (bus.start) begin
                        state_q     <= ST_RESET;
                        prbs_mode_q <= bus.prbs_test_en;
                        retry_q     <= '0;
                        timer_q     <= '0;
                        reset_req_q <= 1'b1;
                        link_fail_q <= 1'b0;
                    end
                end
                ST_RESET: begin
                    if (timer_q == TIMER_W'(RESET_HOLD - 1)) begin
                        state_q     <= ST_WAIT_LOCK;
                        timer_q     <= '0;
                        reset_req_q <= 1'b0;
                    end else begin
                        timer_q <= timer_q + TIMER_W'(1);
                    end
                end
                ST_WAIT_LOCK: begin
                    // A lock seen on the timeout cycle still counts as success.
                    if (lock_ok) begin
                        timer_q <= '0;
                        if (prbs_mode_q) begin
                            state_q     <= ST_PRBS;
                            prbs_en_q   <= 1'b1;
                            err_total_q <= '0;
                        end else begin
                            state_q   <= ST_LINK_UP;
                            link_up_q <= 1'b1;
                            retry_q   <= '0;
                        end
                    end else if (timer_q == TIMER_W'(LOCK_TIMEOUT - 1)) begin
                        timer_q <= '0;
                        if (retry_q == 4'(MAX_RETRIES - 1)) begin
                            state_q     <= ST_FAIL;
                            link_fail_q <= 1'b1;
                        end else begin
                            state_q     <= ST_RESET;
                            retry_q     <= retry_q + 4'd1;
                            reset_req_q <= 1'b1;
                        end
                    end else begin
                        timer_q <= timer_q + TIMER_W'(1);
                    end
                end
                ST_PRBS: begin
                    err_total_q <= err_next;
                    if (timer_q == TIMER_W'(PRBS_CYCLES - 1)) begin
                        timer_q   <= '0;
                        prbs_en_q <= 1'b0;
                        if (prbs_pass) begin
                            state_q   <= ST_LINK_UP;
                            link_up_q <= 1'b1;
                            retry_q   <= '0;
                        end else begin
                            state_q     <= ST_FAIL;
                            link_fail_q <= 1'b1;
                        end
                    end else begin
                        timer_q <= timer_q + TIMER_W'(1);
                    end
                end
                ST_LINK_UP: begin
                    // Link loss restarts as a fresh bring-up; retry_count is already 0 here.
                    if (!lock_ok) begin
                        state_q     <= ST_RESET;
                        timer_q     <= '0;
                        link_up_q   <= 1'b0;
                        reset_req_q <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    reset_req_q <= 1'b0;
                    prbs_en_q   <= 1'b0;
                    link_up_q   <= 1'b0;
                    link_fail_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.state                = state_q;
    assign bus.serdes_rx_reset_req  = reset_req_q;
    assign bus.cfg_tx_prbs31_enable = prbs_en_q;
    assign bus.cfg_rx_prbs31_enable = prbs_en_q;
    assign bus.link_up              = link_up_q;
    assign bus.link_fail            = link_fail_q;
    assign bus.retry_count          = retry_q;
    assign bus.prbs_err_total       = err_total_q;

endmodule

// File: tb/tb_eth_phy_10g_link_ctrl.sv
// Self-checking bench for eth_phy_10g_link_ctrl: expected behaviour is an arithmetic
// timeline of the bring-up phases built from the stimulus chosen for each scenario.
module tb_eth_phy_10g_link_ctrl;

    localparam int RH      = 8;
    localparam int LT      = 1024;
    localparam int MR      = 3;
    localparam int PS      = 16;
    localparam int PC      = 640;
    localparam int PME     = 0;
    localparam int ATTEMPT = RH + LT;

    logic rx_clk = 1'b0;
    logic rx_rst;

    int n_total = 0;
    int n_pass  = 0;
    int exp_retry = 0;
    int exp_total = 0;

    eth_phy_10g_link_ctrl_if bus ();

    eth_phy_10g_link_ctrl #(
        .RESET_HOLD  (RH),
        .LOCK_TIMEOUT(LT),
        .MAX_RETRIES (MR),
        .PRBS_SETTLE (PS),
        .PRBS_CYCLES (PC),
        .PRBS_MAX_ERR(PME)
    ) dut (
        .rx_clk(rx_clk),
        .rx_rst(rx_rst),
        .bus   (bus)
    );

    always #5 rx_clk = ~rx_clk;

    task automatic tick();
        @(posedge rx_clk);
        #1;
    endtask

    // Expected packed status {state, reset_req, cfg_tx, cfg_rx, link_up, link_fail, retry}.
    function automatic logic [11:0] expect_vec(input int st, input int rty);
        return {3'(st), st == 1, st == 3, st == 3, st == 4, st == 5, 4'(rty)};
    endfunction

    function automatic logic [11:0] observe_vec();
        return {bus.state, bus.serdes_rx_reset_req, bus.cfg_tx_prbs31_enable,
                bus.cfg_rx_prbs31_enable, bus.link_up, bus.link_fail, bus.retry_count};
    endfunction

    task automatic test_reset();
        logic [11:0] obs;
        rx_rst = 1'b1;
        bus.start = 1'b0;
        bus.stop = 1'b0;
        bus.prbs_test_en = 1'b0;
        bus.rx_block_lock = 1'b0;
        bus.rx_high_ber = 1'b0;
        bus.rx_error_count = '0;
        repeat (3) tick();
        obs = observe_vec();
        n_total++;
        if (obs !== 12'd0) $display("[TB] FAIL reset_status got %h expected %h", obs, 12'd0);
        else n_pass++;
        n_total++;
        if (bus.prbs_err_total !== 16'd0)
            $display("[TB] FAIL reset_total got %0d expected 0", bus.prbs_err_total);
        else n_pass++;
        rx_rst = 1'b0;
        exp_retry = 0;
        exp_total = 0;
    endtask

    task automatic test_bringup(input string name, input bit prbs, input int a,
                                input int d, input int err_mode);
        int errs[PC];
        int j_lock, j_end, st, rty, t;
        bit locks, ok;
        logic [11:0] obs, expv;
        locks  = (a < MR);
        j_lock = RH + 2 + a * ATTEMPT + d;
        for (int k = 0; k < PC; k++) begin
            case (err_mode)
                1:       errs[k] = (k < PS) ? 5 : 0;
                2:       errs[k] = 127;
                3:       errs[k] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 127)) : 0;
                default: errs[k] = (k < PS) ? int'($urandom_range(0, 127)) : 0;
            endcase
        end
        if (!locks)    j_end = 1 + MR * ATTEMPT + 3;
        else if (prbs) j_end = j_lock + PC + 3;
        else           j_end = j_lock + 3;

        // Return to IDLE; a simultaneous start must lose to stop.
        bus.stop = 1'b1;
        bus.start = 1'b1;
        tick();
        bus.stop = 1'b0;
        obs = observe_vec();
        expv = expect_vec(0, exp_retry);
        n_total++;
        if (obs !== expv) $display("[TB] FAIL %s_stop got %h expected %h", name, obs, expv);
        else n_pass++;

        st = 0;
        ok = 1'b1;
        for (int j = 1; j <= j_end; j++) begin
            bus.start = (j == 1) || (st != 5 && $urandom_range(0, 15) == 0);
            bus.prbs_test_en = (j == 1) ? prbs : 1'($urandom_range(0, 1));
            if (locks && j == j_lock) begin
                bus.rx_block_lock = 1'b1;
                bus.rx_high_ber = 1'b0;
            end else if (!locks || j < j_lock) begin
                bus.rx_block_lock = 1'($urandom_range(0, 1));
                bus.rx_high_ber = bus.rx_block_lock ? 1'b1 : 1'($urandom_range(0, 1));
            end else if (prbs && j <= j_lock + PC) begin
                bus.rx_block_lock = 1'($urandom_range(0, 1));
                bus.rx_high_ber = 1'($urandom_range(0, 1));
            end else begin
                bus.rx_block_lock = 1'b1;
                bus.rx_high_ber = 1'b0;
            end
            if (locks && prbs && j > j_lock && j <= j_lock + PC)
                bus.rx_error_count = 7'(errs[j - j_lock - 1]);
            else
                bus.rx_error_count = 7'($urandom_range(0, 127));
            tick();

            t = j - j_lock - 1;
            if (locks && prbs && j == j_lock) exp_total = 0;
            else if (locks && prbs && t >= PS && t < PC) begin
                exp_total = exp_total + errs[t];
                if (exp_total > 65535) exp_total = 65535;
            end
            if (locks && prbs && j == j_lock + PC) ok = (exp_total <= PME);

            if (locks && j >= j_lock) begin
                if (!prbs)               st = 4;
                else if (j < j_lock + PC) st = 3;
                else                      st = ok ? 4 : 5;
                rty = (st == 4) ? 0 : a;
            end else if (j >= 1 + MR * ATTEMPT) begin
                st = 5;
                rty = MR - 1;
            end else begin
                st = (((j - 1) % ATTEMPT) < RH) ? 1 : 2;
                rty = (j - 1) / ATTEMPT;
            end
            exp_retry = rty;

            obs = observe_vec();
            expv = expect_vec(st, rty);
            n_total++;
            if (obs !== expv)
                $display("[TB] FAIL %s_status cycle %0d got %h expected %h", name, j, obs, expv);
            else n_pass++;
            n_total++;
            if (bus.prbs_err_total !== 16'(exp_total))
                $display("[TB] FAIL %s_total cycle %0d got %0d expected %0d",
                         name, j, bus.prbs_err_total, exp_total);
            else n_pass++;
        end
        bus.start = 1'b0;
    endtask

    task automatic test_link_loss(input bit use_ber);
        logic [11:0] obs, expv;
        int st;
        bus.start = 1'b0;
        bus.rx_block_lock = use_ber;
        bus.rx_high_ber = use_ber;
        for (int k = 1; k <= 12; k++) begin
            tick();
            bus.rx_block_lock = 1'b1;
            bus.rx_high_ber = 1'b0;
            st = (k <= RH) ? 1 : (k == RH + 1) ? 2 : 4;
            obs = observe_vec();
            expv = expect_vec(st, 0);
            n_total++;
            if (obs !== expv)
                $display("[TB] FAIL link_loss%0d cycle %0d got %h expected %h", use_ber, k, obs, expv);
            else n_pass++;
        end
        exp_retry = 0;
    endtask

    task automatic test_random();
        for (int it = 0; it < 6; it++) begin
            test_bringup($sformatf("random%0d", it), 1'($urandom_range(0, 1)),
                         int'($urandom_range(0, MR - 1)), int'($urandom_range(0, LT - 1)),
                         int'($urandom_range(0, 3)));
        end
    endtask

    task automatic test_stop();
        logic [11:0] obs, expv;
        int st, e;
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        bus.start = 1'b1;
        bus.prbs_test_en = 1'b1;
        bus.rx_block_lock = 1'b1;
        bus.rx_high_ber = 1'b0;
        for (int j = 1; j <= 50; j++) begin
            e = int'($urandom_range(0, 127));
            bus.rx_error_count = 7'(e);
            tick();
            bus.start = 1'b0;
            bus.prbs_test_en = 1'b0;
            if (j == RH + 2) exp_total = 0;
            else if (j > RH + 2 && (j - RH - 3) >= PS) exp_total = exp_total + e;
            st = (j <= RH) ? 1 : (j == RH + 1) ? 2 : 3;
            obs = observe_vec();
            expv = expect_vec(st, 0);
            n_total++;
            if (obs !== expv) $display("[TB] FAIL stop_run cycle %0d got %h expected %h", j, obs, expv);
            else n_pass++;
        end
        bus.stop = 1'b1;
        bus.start = 1'b1;
        tick();
        bus.stop = 1'b0;
        bus.start = 1'b0;
        obs = observe_vec();
        n_total++;
        if (obs !== expect_vec(0, 0))
            $display("[TB] FAIL stop_mid_prbs got %h expected %h", obs, expect_vec(0, 0));
        else n_pass++;
        n_total++;
        if (bus.prbs_err_total !== 16'(exp_total))
            $display("[TB] FAIL stop_total_hold got %0d expected %0d", bus.prbs_err_total, exp_total);
        else n_pass++;
        tick();
        obs = observe_vec();
        n_total++;
        if (obs !== expect_vec(0, 0))
            $display("[TB] FAIL stop_start_ignored got %h expected %h", obs, expect_vec(0, 0));
        else n_pass++;

        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        obs = observe_vec();
        n_total++;
        if (obs !== expect_vec(1, 0))
            $display("[TB] FAIL rst_prep got %h expected %h", obs, expect_vec(1, 0));
        else n_pass++;
        rx_rst = 1'b1;
        tick();
        rx_rst = 1'b0;
        obs = observe_vec();
        n_total++;
        if (obs !== 12'd0) $display("[TB] FAIL rst_mid_reset got %h expected %h", obs, 12'd0);
        else n_pass++;
        n_total++;
        if (bus.prbs_err_total !== 16'd0)
            $display("[TB] FAIL rst_mid_total got %0d expected 0", bus.prbs_err_total);
        else n_pass++;
        exp_retry = 0;
        exp_total = 0;
    endtask

    initial begin
        $display("[TB] eth_phy_10g_link_ctrl bench start");
        test_reset();
        test_bringup("lock_path", 1'b0, 0, 0, 0);
        test_link_loss(1'b0);
        test_link_loss(1'b1);
        test_bringup("timeout", 1'b0, MR, 0, 0);
        test_bringup("lock_at_timeout", 1'b0, MR - 1, LT - 1, 0);
        test_bringup("prbs_pass", 1'b1, 0, 0, 1);
        test_bringup("prbs_saturate", 1'b1, 0, 5, 2);
        test_random();
        test_stop();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
